// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared types and constants for the reset sequencer slice.
//   - rst_seq_state_e : sequencer FSM states
//   - RST_SEQ_DLY_W_DFLT : default width of a per-domain delay field
//   Configuration macro: RST_SEQ_READY_HANDSHAKE_EN adds the WAIT_RDY state.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  localparam int unsigned RST_SEQ_DLY_W_DFLT = 8;

  typedef enum logic [2:0] {
    ASSERT,
    COUNT,
`ifdef RST_SEQ_READY_HANDSHAKE_EN
    WAIT_RDY,
`endif
    HOLD,
    DONE
  } rst_seq_state_e;

endpackage

// File: rtl/reset_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
//   Reset synchronizer: asynchronous assertion, synchronous release after
//   SYNC_STAGE clock edges.
//   Ports:
//     clk          : clock
//     i_rst_n      : asynchronous active-low reset input
//     o_rst_sync_n : synchronized active-low reset
// -----------------------------------------------------------------------------
module reset_sync #(
  parameter int unsigned SYNC_STAGE = 3
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_rst_sync_n
);

  logic [SYNC_STAGE-1:0] sync_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGE-2:0], 1'b1};
    end
  end

  assign o_rst_sync_n = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reset_seq_ctrl
//   Releases NUM_DOMAINS active-low resets one after another, domain 0 first.
//   Domain k is released dly[k]+1 cycles after its count is loaded. A level
//   software request forces every domain back into reset for at least
//   HOLD_CYC cycles and then re-runs the sequence.
//   Ports:
//     clk          : clock
//     i_rst_n      : asynchronous active-low reset
//     i_sw_rst_req : level software reset request
//     i_dly        : NUM_DOMAINS packed DLY_W-bit delay fields (field k = domain k)
//     i_dom_rdy    : per-domain ready (used only with the handshake macro)
//     o_rst_n      : per-domain active-low resets
//     o_seq_done   : all domains released
//     o_busy       : sequencer not in DONE
//   Configuration macro: RST_SEQ_READY_HANDSHAKE_EN -- after each release,
//   wait for i_dom_rdy[idx] before counting the next domain.
// -----------------------------------------------------------------------------
module reset_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned SYNC_STAGE  = 3,
  parameter int unsigned DLY_W       = RST_SEQ_DLY_W_DFLT,
  parameter int unsigned HOLD_CYC    = 16
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_sw_rst_req,
  input  logic [NUM_DOMAINS*DLY_W-1:0] i_dly,
  input  logic [NUM_DOMAINS-1:0]       i_dom_rdy,
  output logic [NUM_DOMAINS-1:0]       o_rst_n,
  output logic                         o_seq_done,
  output logic                         o_busy
);

  localparam int unsigned IDX_W  = $clog2(NUM_DOMAINS);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  // hold_cnt lags elapsed HOLD cycles by one, so the exit edge sees HOLD_CYC-1
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

  logic                    rst_sync_n;
  logic [DLY_W-1:0]        dly_arr [NUM_DOMAINS];

  rst_seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]        idx_q,   idx_d;
  logic [DLY_W-1:0]        cnt_q,   cnt_d;
  logic [HOLD_W-1:0]       hold_q,  hold_d;
  logic [NUM_DOMAINS-1:0]  rst_q,   rst_d;
  logic                    done_q,  done_d;

  logic [IDX_W-1:0]        nxt_idx;
  logic                    hold_met;

  reset_sync #(
    .SYNC_STAGE (SYNC_STAGE)
  ) u_reset_sync (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .o_rst_sync_n (rst_sync_n)
  );

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dly
    assign dly_arr[k] = i_dly[k*DLY_W +: DLY_W];
  end

`ifndef RST_SEQ_READY_HANDSHAKE_EN
  logic dom_rdy_unused;
  assign dom_rdy_unused = ^i_dom_rdy;
`endif

  assign nxt_idx  = idx_q + 1'b1;
  assign hold_met = (hold_q >= HOLD_LAST);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ASSERT;
      idx_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rst_d   = rst_q;
    done_d  = done_q;

    case (state_q)
      ASSERT: begin
        if (rst_sync_n) begin
          idx_d   = '0;
          cnt_d   = dly_arr[0];
          state_d = COUNT;
        end
      end

      COUNT: begin
        // software request wins over a release due on the same edge
        if (i_sw_rst_req) begin
          state_d = HOLD;
          rst_d   = '0;
          done_d  = 1'b0;
          hold_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rst_d[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
`ifdef RST_SEQ_READY_HANDSHAKE_EN
            state_d = WAIT_RDY;
`else
            idx_d = nxt_idx;
            cnt_d = dly_arr[nxt_idx];
`endif
          end
        end
      end

`ifdef RST_SEQ_READY_HANDSHAKE_EN
      WAIT_RDY: begin
        if (i_sw_rst_req) begin
          state_d = HOLD;
          rst_d   = '0;
          done_d  = 1'b0;
          hold_d  = '0;
        end else if (i_dom_rdy[idx_q]) begin
          idx_d   = nxt_idx;
          cnt_d   = dly_arr[nxt_idx];
          state_d = COUNT;
        end
      end
`endif

      HOLD: begin
        if (!i_sw_rst_req && hold_met) begin
          idx_d   = '0;
          cnt_d   = dly_arr[0];
          state_d = COUNT;
        end else if (!hold_met) begin
          hold_d = hold_q + 1'b1;
        end
      end

      DONE: begin
        if (i_sw_rst_req) begin
          state_d = HOLD;
          rst_d   = '0;
          done_d  = 1'b0;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = ASSERT;
      end
    endcase
  end

  assign o_rst_n    = rst_q;
  assign o_seq_done = done_q;
  assign o_busy     = (state_q != DONE);

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reset_seq_ctrl
//   Directed bench for reset_seq_ctrl with NUM_DOMAINS=4, delays {2,0,5,1},
//   HOLD_CYC=16, SYNC_STAGE=3. Edge numbers below count posedges after the
//   stimulus point; outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_reset_seq_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 8;
`ifdef RST_SEQ_READY_HANDSHAKE_EN
  localparam int unsigned HS = 1;
`else
  localparam int unsigned HS = 0;
`endif
  localparam logic [ND*DW-1:0] DLY_DFLT = {8'd1, 8'd5, 8'd0, 8'd2};

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_sw_rst_req;
  logic [ND*DW-1:0]  i_dly;
  logic [ND-1:0]     i_dom_rdy;
  logic [ND-1:0]     o_rst_n;
  logic              o_seq_done;
  logic              o_busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  reset_seq_ctrl #(
    .NUM_DOMAINS (ND),
    .SYNC_STAGE  (3),
    .DLY_W       (DW),
    .HOLD_CYC    (16)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_sw_rst_req (i_sw_rst_req),
    .i_dly        (i_dly),
    .i_dom_rdy    (i_dom_rdy),
    .o_rst_n      (o_rst_n),
    .o_seq_done   (o_seq_done),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Assert the hard reset over two edges, release it mid-cycle.
  task automatic hard_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Records the edge at which each bit and o_seq_done rise. 'entry' is the
  // edge on which COUNT is entered for domain 0, d0 is domain 0's delay.
  task automatic track_seq(input string tag, input int unsigned entry, input int unsigned d0);
    int unsigned rise [ND];
    int unsigned exp_t [ND];
    int unsigned done_t;
    int unsigned budget;
    done_t   = 0;
    exp_t[0] = entry + d0 + 1;
    exp_t[1] = exp_t[0] + 1 + HS;
    exp_t[2] = exp_t[1] + 6 + HS;
    exp_t[3] = exp_t[2] + 2 + HS;
    budget   = exp_t[3] + 20;
    for (int k = 0; k < ND; k++) rise[k] = 0;
    for (int unsigned n = 1; n <= budget && done_t == 0; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
        if (o_rst_n[k] && rise[k] == 0) rise[k] = n;
      end
      if (o_seq_done) done_t = n;
    end
    for (int k = 0; k < ND; k++) begin
      check_val($sformatf("%s_b%0d_rise", tag, k), rise[k], exp_t[k]);
    end
    check_val($sformatf("%s_done_rise", tag), done_t, exp_t[3]);
    check_val($sformatf("%s_busy_end", tag), 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_sw_rst_req = 1'b0;
    i_dly        = DLY_DFLT;
    i_dom_rdy    = '1;

    // power-on: reset state, then sequence; sync releases on edge 3, COUNT on 4
    repeat (3) @(posedge clk);
    #1;
    check_val("por_rst_n", 32'(o_rst_n), 32'd0);
    check_val("por_done", 32'(o_seq_done), 32'd0);
    check_val("por_busy", 32'(o_busy), 32'd1);
    i_rst_n = 1'b1;
    track_seq("por", 4, 2);

    // hard reset while bits 0 and 1 are released, no clock edge in between
    hard_reset();
    repeat (10) @(posedge clk);
    #1;
    check_val("mid_pre", 32'(o_rst_n), 32'd3);
    i_rst_n = 1'b0;
    #2;
    check_val("mid_rst_n", 32'(o_rst_n), 32'd0);
    check_val("mid_done", 32'(o_seq_done), 32'd0);
    check_val("mid_busy", 32'(o_busy), 32'd1);
    #2;
    i_rst_n = 1'b1;
    track_seq("mid_restart", 4, 2);

    // one-cycle software reset in DONE: HOLD entered on edge 0, COUNT on 16
    @(negedge clk);
    i_sw_rst_req = 1'b1;
    @(posedge clk);
    #1;
    check_val("sw_rst_n", 32'(o_rst_n), 32'd0);
    check_val("sw_done", 32'(o_seq_done), 32'd0);
    check_val("sw_busy", 32'(o_busy), 32'd1);
    i_sw_rst_req = 1'b0;
    track_seq("sw_short", 16, 2);

    // request held for 40 sampled edges: COUNT on the first edge it is low
    @(negedge clk);
    i_sw_rst_req = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("sw_long_rst_n", 32'(o_rst_n), 32'd0);
    check_val("sw_long_busy", 32'(o_busy), 32'd1);
    i_sw_rst_req = 1'b0;
    track_seq("sw_long", 1, 2);

    // request on the edge that would release domain 2
    hard_reset();
    repeat (13 + 2*HS) @(posedge clk);
    #1;
    check_val("col_pre", 32'(o_rst_n), 32'd3);
    i_sw_rst_req = 1'b1;
    @(posedge clk);
    #1;
    check_val("col_rst_n", 32'(o_rst_n), 32'd0);
    check_val("col_done", 32'(o_seq_done), 32'd0);
    check_val("col_busy", 32'(o_busy), 32'd1);
    i_sw_rst_req = 1'b0;
    track_seq("col_rerun", 16, 2);

    // maximum delay field: 256 cycles from COUNT entry to release
    i_dly[7:0] = 8'd255;
    hard_reset();
    track_seq("max_dly", 4, 255);
    i_dly = DLY_DFLT;

`ifdef RST_SEQ_READY_HANDSHAKE_EN
    // handshake: domain 0 not ready for 10 cycles after release
    i_dom_rdy = '0;
    hard_reset();
    repeat (7) @(posedge clk);
    #1;
    check_val("hs_b0", 32'(o_rst_n), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check_val("hs_wait", 32'(o_rst_n), 32'd1);
    i_dom_rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check_val("hs_load", 32'(o_rst_n), 32'd1);
    @(posedge clk);
    #1;
    check_val("hs_b1", 32'(o_rst_n), 32'd3);
    i_dom_rdy = '1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
